// File: rtl/pc_ctrl_if.sv
// Bundle between the PC sequencer and its surroundings: decoded branch/halt
// info, flags, stall, LUT write port in; PC control and status out.
interface pc_ctrl_if #(
    parameter int PCW  = 16,
    parameter int LUTA = 5,
    parameter int CNTW = 16
);
    logic            Start;
    logic            Is_Branch;
    logic            Br_Dir;
    logic [1:0]      Br_Cond;
    logic [LUTA-1:0] Br_Idx;
    logic            Is_Halt;
    logic            Flag_We;
    logic            Zero_In;
    logic            Neg_In;
    logic            Mem_Busy;
    logic            Lut_We;
    logic [LUTA-1:0] Lut_Addr;
    logic [PCW-1:0]  Lut_Data;
    logic            For_Jump;
    logic            Back_Jump;
    logic [PCW-1:0]  Offset;
    logic            Halt;
    logic            Pc_Clear;
    logic            Done;
    logic [CNTW-1:0] Cycle_Cnt;

    modport slave (
        input  Start, Is_Branch, Br_Dir, Br_Cond, Br_Idx, Is_Halt, Flag_We,
               Zero_In, Neg_In, Mem_Busy, Lut_We, Lut_Addr, Lut_Data,
        output For_Jump, Back_Jump, Offset, Halt, Pc_Clear, Done, Cycle_Cnt
    );

    modport master (
        output Start, Is_Branch, Br_Dir, Br_Cond, Br_Idx, Is_Halt, Flag_We,
               Zero_In, Neg_In, Mem_Busy, Lut_We, Lut_Addr, Lut_Data,
        input  For_Jump, Back_Jump, Offset, Halt, Pc_Clear, Done, Cycle_Cnt
    );
endinterface

// File: rtl/pc_ctrl.sv
// Program-counter sequencer: start/stall/halt FSM, registered Z/N flags,
// branch-offset LUT and saturating run-cycle counter. PC controls are Mealy.
module pc_ctrl #(
    parameter int PCW  = 16,
    parameter int LUTA = 5,
    parameter int CNTW = 16
) (
    input logic         CLK,
    input logic         Reset,
    pc_ctrl_if.slave    bus
);
    localparam int NENT = 2 ** LUTA;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        STALL = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            z_q, z_d;
    logic            n_q, n_d;
    logic            done_q, done_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [CNTW-1:0] cnt_inc;
    logic [PCW-1:0]  lut_rd [NENT];

    logic            cond_ok;
    logic            taken;
    logic            for_jump;
    logic            back_jump;
    logic [PCW-1:0]  offset;
    logic            halt;
    logic            pc_clear;

    // Each LUT entry is its own resettable register; reads are combinational
    // and see the pre-write value during a same-cycle write.
    genvar gi;
    generate
        for (gi = 0; gi < NENT; gi++) begin : g_lut
            logic [PCW-1:0] entry_q, entry_d;

            always_comb begin
                entry_d = entry_q;
                if (bus.Lut_We && (bus.Lut_Addr == LUTA'(gi)))
                    entry_d = bus.Lut_Data;
            end

            always_ff @(posedge CLK) begin
                if (Reset) entry_q <= '0;
                else       entry_q <= entry_d;
            end

            assign lut_rd[gi] = entry_q;
        end
    endgenerate

    always_comb begin
        cond_ok = 1'b1;
        case (bus.Br_Cond)
            2'b00:   cond_ok = 1'b1;
            2'b01:   cond_ok = z_q;
            2'b10:   cond_ok = ~z_q;
            default: cond_ok = n_q;
        endcase
    end

    assign taken   = bus.Is_Branch & cond_ok;
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNTW'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        z_d       = bus.Flag_We ? bus.Zero_In : z_q;
        n_d       = bus.Flag_We ? bus.Neg_In  : n_q;
        for_jump  = 1'b0;
        back_jump = 1'b0;
        offset    = '0;
        halt      = 1'b1;
        pc_clear  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.Start) state_d = CLEAR;
            end
            CLEAR: begin
                pc_clear = 1'b1;
                cnt_d    = '0;
                done_d   = 1'b0;
                state_d  = RUN;
            end
            RUN: begin
                cnt_d = cnt_inc;
                if (bus.Mem_Busy) begin
                    state_d = STALL;
                end else if (bus.Is_Halt) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    halt = 1'b0;
                    if (taken) begin
                        for_jump  = ~bus.Br_Dir;
                        back_jump = bus.Br_Dir;
                        offset    = lut_rd[bus.Br_Idx];
                    end
                end
            end
            STALL: begin
                cnt_d = cnt_inc;
                // The held instruction is re-evaluated in RUN next cycle.
                if (!bus.Mem_Busy) state_d = RUN;
            end
            DONE: begin
                if (bus.Start) state_d = CLEAR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
            n_q     <= n_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.For_Jump  = for_jump;
    assign bus.Back_Jump = back_jump;
    assign bus.Offset    = offset;
    assign bus.Halt      = halt;
    assign bus.Pc_Clear  = pc_clear;
    assign bus.Done      = done_q;
    assign bus.Cycle_Cnt = cnt_q;
endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: stimulus pushes hand-computed expectations into
// a scoreboard queue, a monitor pops and compares on each falling edge.
module tb_pc_ctrl;
    localparam int PCW  = 16;
    localparam int LUTA = 5;
    localparam int CW   = 10;   // narrow counter so saturation is reachable quickly

    logic clk;
    logic rst;

    pc_ctrl_if #(.PCW(PCW), .LUTA(LUTA), .CNTW(CW)) bus_if ();

    pc_ctrl #(.PCW(PCW), .LUTA(LUTA), .CNTW(CW)) dut (
        .CLK   (clk),
        .Reset (rst),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string          name;
        logic           fj;
        logic           bj;
        logic [PCW-1:0] off;
        logic           h;
        logic           clr;
        logic           dn;
        int             cnt;   // negative: counter not checked
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic clear_inputs();
        bus_if.Start     = 1'b0;
        bus_if.Is_Branch = 1'b0;
        bus_if.Br_Dir    = 1'b0;
        bus_if.Br_Cond   = 2'b00;
        bus_if.Br_Idx    = '0;
        bus_if.Is_Halt   = 1'b0;
        bus_if.Flag_We   = 1'b0;
        bus_if.Zero_In   = 1'b0;
        bus_if.Neg_In    = 1'b0;
        bus_if.Mem_Busy  = 1'b0;
        bus_if.Lut_We    = 1'b0;
        bus_if.Lut_Addr  = '0;
        bus_if.Lut_Data  = '0;
        rst              = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic br(input logic [1:0] c, input logic d, input int idx);
        bus_if.Is_Branch = 1'b1;
        bus_if.Br_Cond   = c;
        bus_if.Br_Dir    = d;
        bus_if.Br_Idx    = LUTA'(idx);
    endtask

    task automatic lutw(input int a, input logic [PCW-1:0] v);
        bus_if.Lut_We   = 1'b1;
        bus_if.Lut_Addr = LUTA'(a);
        bus_if.Lut_Data = v;
    endtask

    task automatic ex(input string nm, input logic fj, input logic bj,
                      input logic [PCW-1:0] off, input logic h, input logic clr,
                      input logic dn, input int cnt);
        exp_t e;
        e.name = nm; e.fj = fj; e.bj = bj; e.off = off;
        e.h = h; e.clr = clr; e.dn = dn; e.cnt = cnt;
        sb.push_back(e);
    endtask

    // Monitor: every queued expectation belongs to the current cycle.
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                exp_t e;
                logic bad;
                e = sb.pop_front();
                checks++;
                bad = (bus_if.For_Jump !== e.fj) || (bus_if.Back_Jump !== e.bj) ||
                      (bus_if.Offset !== e.off) || (bus_if.Halt !== e.h) ||
                      (bus_if.Pc_Clear !== e.clr) || (bus_if.Done !== e.dn) ||
                      ((e.cnt >= 0) && (bus_if.Cycle_Cnt !== CW'(e.cnt)));
                if (bad) begin
                    errors++;
                    $display("FAIL %s: got fj=%b bj=%b off=%h halt=%b clr=%b done=%b cnt=%0d, want fj=%b bj=%b off=%h halt=%b clr=%b done=%b cnt=%0d",
                             e.name, bus_if.For_Jump, bus_if.Back_Jump, bus_if.Offset,
                             bus_if.Halt, bus_if.Pc_Clear, bus_if.Done, bus_if.Cycle_Cnt,
                             e.fj, e.bj, e.off, e.h, e.clr, e.dn, e.cnt);
                end else begin
                    $display("ok   %s: fj=%b bj=%b off=%h halt=%b clr=%b done=%b cnt=%0d",
                             e.name, bus_if.For_Jump, bus_if.Back_Jump, bus_if.Offset,
                             bus_if.Halt, bus_if.Pc_Clear, bus_if.Done, bus_if.Cycle_Cnt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        cyc(); rst = 1'b1;
        cyc();
        ex("reset", 0, 0, 16'h0000, 1, 0, 0, 0);

        // Start, one-cycle clear, plain run
        cyc(); bus_if.Start = 1'b1; ex("idle_start", 0, 0, 16'h0000, 1, 0, 0, 0);
        cyc(); ex("clear", 0, 0, 16'h0000, 1, 1, 0, 0);
        cyc(); ex("run1", 0, 0, 16'h0000, 0, 0, 0, 0);
        cyc(); ex("run2", 0, 0, 16'h0000, 0, 0, 0, 1);
        cyc(); ex("run3", 0, 0, 16'h0000, 0, 0, 0, 2);
        cyc(); ex("run4", 0, 0, 16'h0000, 0, 0, 0, 3);

        // LUT[3]=5, Z=1, conditional branches
        cyc(); lutw(3, 16'h0005); bus_if.Flag_We = 1'b1; bus_if.Zero_In = 1'b1;
        ex("lut_flag_wr", 0, 0, 16'h0000, 0, 0, 0, 4);
        cyc(); br(2'b01, 1'b0, 3); ex("fwd_if_z", 1, 0, 16'h0005, 0, 0, 0, 5);
        cyc(); br(2'b01, 1'b1, 3); ex("back_if_z", 0, 1, 16'h0005, 0, 0, 0, 6);
        cyc(); br(2'b10, 1'b0, 3); ex("no_jump_nz", 0, 0, 16'h0000, 0, 0, 0, 7);
        cyc(); br(2'b11, 1'b0, 3); ex("n_ignores_z", 0, 0, 16'h0000, 0, 0, 0, 8);

        // Same-cycle flag write uses old flags
        cyc(); bus_if.Flag_We = 1'b1; bus_if.Zero_In = 1'b0;
        ex("z_clear", 0, 0, 16'h0000, 0, 0, 0, 9);
        cyc(); br(2'b01, 1'b0, 3); bus_if.Flag_We = 1'b1; bus_if.Zero_In = 1'b1;
        ex("old_flag", 0, 0, 16'h0000, 0, 0, 0, 10);
        cyc(); br(2'b01, 1'b0, 3); ex("new_flag", 1, 0, 16'h0005, 0, 0, 0, 11);

        // LUT read-before-write
        cyc(); br(2'b00, 1'b0, 3); lutw(3, 16'h0009);
        ex("lut_rbw_old", 1, 0, 16'h0005, 0, 0, 0, 12);
        cyc(); br(2'b00, 1'b0, 3); ex("lut_rbw_new", 1, 0, 16'h0009, 0, 0, 0, 13);

        // Memory stall over a taken backward branch
        cyc(); br(2'b00, 1'b1, 3); bus_if.Mem_Busy = 1'b1; ex("busy0", 0, 0, 16'h0000, 1, 0, 0, 14);
        cyc(); br(2'b00, 1'b1, 3); bus_if.Mem_Busy = 1'b1; ex("busy1", 0, 0, 16'h0000, 1, 0, 0, 15);
        cyc(); br(2'b00, 1'b1, 3); bus_if.Mem_Busy = 1'b1; ex("busy2", 0, 0, 16'h0000, 1, 0, 0, 16);
        cyc(); br(2'b00, 1'b1, 3); ex("stall_exit", 0, 0, 16'h0000, 1, 0, 0, 17);
        cyc(); br(2'b00, 1'b1, 3); ex("jump_once", 0, 1, 16'h0009, 0, 0, 0, 18);
        cyc(); ex("after_jump", 0, 0, 16'h0000, 0, 0, 0, 19);

        // Halt beats branch; restart from DONE
        cyc(); br(2'b00, 1'b0, 3); bus_if.Is_Halt = 1'b1; ex("halt_over_br", 0, 0, 16'h0000, 1, 0, 0, 20);
        cyc(); ex("done1", 0, 0, 16'h0000, 1, 0, 1, 21);
        cyc(); bus_if.Start = 1'b1; ex("done2_start", 0, 0, 16'h0000, 1, 0, 1, 21);
        cyc(); ex("restart_clear", 0, 0, 16'h0000, 1, 1, 1, 21);
        cyc(); ex("rerun", 0, 0, 16'h0000, 0, 0, 0, 0);
        cyc(); bus_if.Start = 1'b1; ex("start_in_run", 0, 0, 16'h0000, 0, 0, 0, 1);
        cyc(); ex("start_ignored", 0, 0, 16'h0000, 0, 0, 0, 2);

        // Reset mid-stall with a pending LUT write and Start
        cyc(); bus_if.Mem_Busy = 1'b1; ex("busy_a", 0, 0, 16'h0000, 1, 0, 0, 3);
        cyc(); bus_if.Mem_Busy = 1'b1; ex("busy_b", 0, 0, 16'h0000, 1, 0, 0, 4);
        cyc(); bus_if.Mem_Busy = 1'b1; rst = 1'b1; bus_if.Start = 1'b1; lutw(0, 16'hFFFF);
        ex("rst_in_stall", 0, 0, 16'h0000, 1, 0, 0, 5);
        cyc(); ex("rst_idle", 0, 0, 16'h0000, 1, 0, 0, 0);
        cyc(); bus_if.Start = 1'b1; ex("idle_start2", 0, 0, 16'h0000, 1, 0, 0, 0);
        cyc(); ex("clear3", 0, 0, 16'h0000, 1, 1, 0, 0);
        cyc(); br(2'b00, 1'b0, 0); ex("lut0_cleared", 1, 0, 16'h0000, 0, 0, 0, 0);
        cyc(); br(2'b00, 1'b0, 3); ex("lut3_cleared", 1, 0, 16'h0000, 0, 0, 0, 1);

        // Long run to saturation at all-ones
        for (int i = 0; i < 1020; i++) cyc();
        cyc(); ex("pre_sat", 0, 0, 16'h0000, 0, 0, 0, 1022);
        cyc(); ex("sat", 0, 0, 16'h0000, 0, 0, 0, 1023);
        cyc(); ex("sat_hold", 0, 0, 16'h0000, 0, 0, 0, 1023);
        cyc(); bus_if.Is_Halt = 1'b1; ex("sat_halt", 0, 0, 16'h0000, 1, 0, 0, 1023);
        cyc(); ex("sat_done", 0, 0, 16'h0000, 1, 0, 1, 1023);

        cyc();
        cyc();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Sequencer for the program counter / fetch stage.
- Owns program start, stall and halt, and a 32-entry branch-offset LUT.
- Each cycle it drives For_Jump, Back_Jump, Offset and Halt into the PC register from decoded branch/halt info, ALU flags and a memory-busy stall.
- Counts executed cycles and reports Done, so the top level can run, restart and measure programs.

Parameters:
- PCW, 16, PC and offset width.
- LUTA, 5, branch-LUT address width (2**LUTA entries).
- CNTW, 16, cycle-counter width.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high; clears all state.
- Start  in  1  pulse; begins or restarts a program.
- Is_Branch  in  1  decoded: current instruction is a branch.
- Br_Dir  in  1  0 = forward (PC+off), 1 = backward (PC-off).
- Br_Cond  in  2  00 always, 01 if Z, 10 if !Z, 11 if N.
- Br_Idx  in  LUTA  LUT index supplying the offset.
- Is_Halt  in  1  decoded halt instruction.
- Flag_We  in  1  latch ALU flags this cycle.
- Zero_In  in  1  ALU zero flag.
- Neg_In  in  1  ALU negative flag.
- Mem_Busy  in  1  data memory busy; freeze PC.
- Lut_We  in  1  LUT write enable.
- Lut_Addr  in  LUTA  LUT write address.
- Lut_Data  in  PCW  LUT write data.
- For_Jump  out  1  to PC: PC <= PC+Offset.
- Back_Jump  out  1  to PC: PC <= PC-Offset.
- Offset  out  PCW  branch offset to PC.
- Halt  out  1  to PC: hold PC.
- Pc_Clear  out  1  OR'd into the PC reset; one-cycle pulse.
- Done  out  1  program halted.
- Cycle_Cnt  out  CNTW  cycles spent in RUN+STALL.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high.
- Reset values: state IDLE, Z/N flag regs 0, all LUT entries 0, Cycle_Cnt 0, Done 0.
- Registered vs combinational outputs: Cycle_Cnt and Done are registered. For_Jump, Back_Jump, Offset, Halt and Pc_Clear are combinational from state, inputs and registered flags/LUT (Mealy); the PC consumes them at the same edge.
- States: IDLE, CLEAR, RUN, STALL, DONE.
- IDLE:
  - Outputs: Halt=1, jumps 0, Offset 0.
  - Start -> CLEAR.
- CLEAR (exactly one cycle):
  - Outputs: Pc_Clear=1, Halt=1.
  - Actions: Cycle_Cnt <= 0, Done <= 0.
  - -> RUN.
- RUN, priority Mem_Busy > Is_Halt > taken branch > advance:
  - Mem_Busy: Halt=1, -> STALL.
  - Is_Halt (no busy): Halt=1, -> DONE, Done <= 1 next cycle. Halt wins over a simultaneous Is_Branch.
  - Taken branch:
    - Taken = Is_Branch & cond(Br_Cond, Zreg, Nreg).
    - Drive For_Jump=!Br_Dir, Back_Jump=Br_Dir, Offset=LUT[Br_Idx].
    - Stay in RUN.
  - Otherwise: all of For_Jump, Back_Jump, Halt are 0 (PC+1).
  - Offset is 0 whenever neither jump is asserted.
  - For_Jump and Back_Jump are never both 1.
- STALL:
  - Halt=1; the same instruction stays presented.
  - !Mem_Busy -> RUN. The instruction is then evaluated in RUN on the following cycle, with no lost or duplicated PC step.
- DONE:
  - Halt=1, Done=1.
  - Start -> CLEAR (restart); otherwise hold.
- Cycle_Cnt:
  - +1 each cycle in RUN or STALL; saturates at all-ones (no wrap).
  - Holds in IDLE and DONE.
- Flags:
  - Zreg/Nreg <= Zero_In/Neg_In when Flag_We, in any state.
  - A branch in the same cycle as Flag_We uses the old (registered) flags.
- LUT:
  - Write on Lut_We in any state.
  - Read-before-write: a branch reading the index being written that cycle gets the old value.
- Br_Cond=11 (N) ignores Z.
- Offset is used unsigned-magnitude as presented; direction comes only from Br_Dir. Arithmetic wraps modulo 2**PCW in the PC.
- Start while in RUN or STALL is ignored.
- Reset in any state overrides everything within one cycle, including a pending Start and Lut_We that same cycle.

Test Plan:
1. Reset, then Start:
   - Pc_Clear=1 for exactly one cycle, then RUN.
   - With no branches, For/Back/Halt all 0.
   - Cycle_Cnt increments 1,2,3.
2. LUT[3]=0x0005; Flag_We with Zero_In=1; then Is_Branch, Br_Cond=01, Br_Dir=0, Br_Idx=3:
   - For_Jump=1, Offset=0x0005.
   - Repeat with Br_Dir=1: Back_Jump=1.
   - With Br_Cond=10: no jump, Offset=0.
3. Zreg=0; same cycle Flag_We with Zero_In=1 and branch Br_Cond=01:
   - No jump (old flag used).
   - Next-cycle identical branch jumps.
4. Mem_Busy high for 3 cycles over a taken-branch instruction:
   - Halt=1 for 3 cycles, no jump asserted.
   - Jump fires exactly once after Mem_Busy drops.
   - Cycle_Cnt counts stall cycles.
5. Is_Halt and Is_Branch both high in RUN:
   - No jump, Halt=1, Done=1 next cycle.
   - Cycle_Cnt frozen.
   - Start -> Pc_Clear pulse, Cycle_Cnt=0, Done=0.
6. Reset asserted mid-STALL with Lut_We to LUT[0]=0xFFFF:
   - Next cycle IDLE, LUT[0]=0, Halt=1, Done=0, Cycle_Cnt=0.
   - Also: preload Cycle_Cnt near 0xFFFF via a long run and confirm it saturates at 0xFFFF.
